// File: rtl/dpram_arb_pkg.sv
// Shared types and default sizes for the dual-port RAM access arbiter.
package dpram_arb_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_NUM_REQ    = 4;

    // INIT sweeps zeros into the RAM; RUN arbitrates requester traffic.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dpram_access_arbiter_rr_pick.sv
// Circular first-one finder: returns the first set bit of mask at or after start.
module rr_pick #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    mask,
    input  logic [IDXW-1:0] start,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    logic [IDXW-1:0] pos;

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = IDXW'((int'(start) + k) % N);
            if (mask[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/dpram_access_arbiter.sv
// Shares a dual-port RAM between NUM_REQ requesters: clears the RAM after
// reset, then grants up to two requests per cycle (port A, port B) with
// round-robin priority and returns read data one cycle after the grant.
//
// Handshake: a request transfers in the cycle where req_valid[i] and
// req_ready[i] are both high; req_ready is combinational from req_valid and
// the round-robin pointer, so requesters hold valid/we/addr/wdata until then.
module dpram_access_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_data,
    output logic                             init_done,
    output logic                             ram_we_a,
    output logic                             ram_we_b,
    output logic [ADDR_WIDTH-1:0]            ram_addr_a,
    output logic [ADDR_WIDTH-1:0]            ram_addr_b,
    output logic [DATA_WIDTH-1:0]            ram_din_a,
    output logic [DATA_WIDTH-1:0]            ram_din_b,
    input  logic [DATA_WIDTH-1:0]            ram_dout_a,
    input  logic [DATA_WIDTH-1:0]            ram_dout_b
);

    localparam int IDXW = $clog2(NUM_REQ);

    arb_state_t              state;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic [IDXW-1:0]         rr_ptr;
    logic                    tag_va, tag_vb;
    logic [IDXW-1:0]         tag_ia, tag_ib;

    logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];

    logic                    found_a, found_b;
    logic [IDXW-1:0]         idx_a, idx_b, start_b, next_b, rr_next;
    logic [NUM_REQ-1:0]      mask_b;
    logic                    collide, gnt_a, gnt_b;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign start_b = IDXW'((int'(idx_a) + 1) % NUM_REQ);
    assign next_b  = IDXW'((int'(idx_b) + 1) % NUM_REQ);

    // Port B searches the remaining requesters, starting just after A.
    always_comb begin
        mask_b        = req_valid;
        mask_b[idx_a] = 1'b0;
    end

    rr_pick #(.N(NUM_REQ), .IDXW(IDXW)) u_pick_a (
        .mask  (req_valid),
        .start (rr_ptr),
        .found (found_a),
        .idx   (idx_a)
    );

    rr_pick #(.N(NUM_REQ), .IDXW(IDXW)) u_pick_b (
        .mask  (mask_b),
        .start (start_b),
        .found (found_b),
        .idx   (idx_b)
    );

    assign collide = (addr_arr[idx_a] == addr_arr[idx_b]) && (req_we[idx_a] || req_we[idx_b]);
    assign gnt_a   = (state == RUN) && found_a;
    assign gnt_b   = gnt_a && found_b && !collide;
    assign rr_next = gnt_b ? next_b : (gnt_a ? start_b : rr_ptr);

    // Grants and RAM port drive; the sweep write is held off while reset is low.
    always_comb begin
        req_ready  = '0;
        ram_we_a   = 1'b0;
        ram_addr_a = '0;
        ram_din_a  = '0;
        ram_we_b   = 1'b0;
        ram_addr_b = '0;
        ram_din_b  = '0;
        if (state == INIT) begin
            ram_we_a   = rst_n;
            ram_addr_a = init_cnt;
        end else if (gnt_a) begin
            req_ready[idx_a] = 1'b1;
            ram_we_a         = req_we[idx_a];
            ram_addr_a       = addr_arr[idx_a];
            ram_din_a        = wdata_arr[idx_a];
        end
        if (gnt_b) begin
            req_ready[idx_b] = 1'b1;
            ram_we_b         = req_we[idx_b];
            ram_addr_b       = addr_arr[idx_b];
            ram_din_b        = wdata_arr[idx_b];
        end
    end

    // Controller state, clear sweep, round-robin pointer and read-response tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            init_cnt  <= '0;
            rr_ptr    <= '0;
            init_done <= 1'b0;
            tag_va    <= 1'b0;
            tag_vb    <= 1'b0;
            tag_ia    <= '0;
            tag_ib    <= '0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    rr_ptr <= rr_next;
                end
                default: state <= INIT;
            endcase
            tag_va <= gnt_a && !req_we[idx_a];
            tag_vb <= gnt_b && !req_we[idx_b];
            tag_ia <= idx_a;
            tag_ib <= idx_b;
        end
    end

    // Route each port's registered read data back to the requester that asked.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tag_va && (tag_ia == IDXW'(i))) begin
                rsp_valid[i]                        = 1'b1;
                rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = ram_dout_a;
            end else if (tag_vb && (tag_ib == IDXW'(i))) begin
                rsp_valid[i]                        = 1'b1;
                rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = ram_dout_b;
            end
        end
    end

endmodule

// File: tb/tb_dpram_access_arbiter.sv
// Bench for dpram_access_arbiter: behavioural dual-port RAM, directed
// request vectors, and a response scoreboard fed at grant time.
module tb_dpram_access_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_we;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        init_done;
    logic        ram_we_a, ram_we_b;
    logic [2:0]  ram_addr_a, ram_addr_b;
    logic [7:0]  ram_din_a, ram_din_b;
    logic [7:0]  ram_dout_a, ram_dout_b;

    logic [7:0]  mem [8];
    logic        seed;

    logic [9:0]  exp_q [$];
    logic [9:0]  mon_e;
    int          n_cmp;
    int          n_fail;

    dpram_access_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .init_done  (init_done),
        .ram_we_a   (ram_we_a),
        .ram_we_b   (ram_we_b),
        .ram_addr_a (ram_addr_a),
        .ram_addr_b (ram_addr_b),
        .ram_din_a  (ram_din_a),
        .ram_din_b  (ram_din_b),
        .ram_dout_a (ram_dout_a),
        .ram_dout_b (ram_dout_b)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port RAM with registered reads; seed fills it with non-zero junk.
    always @(posedge clk) begin
        if (seed) begin
            for (int k = 0; k < 8; k++) mem[k] <= 8'hC3 ^ 8'(k);
        end else begin
            if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
            if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
        end
        ram_dout_a <= mem[ram_addr_a];
        ram_dout_b <= mem[ram_addr_b];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int idx, input logic [7:0] d);
        exp_q.push_back({2'(idx), d});
    endtask

    function automatic logic [11:0] pa(input logic [2:0] a3, input logic [2:0] a2,
                                       input logic [2:0] a1, input logic [2:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    // One cycle of requests; grant vector checked mid-cycle.
    task automatic step(input string nm, input logic [3:0] v, input logic [3:0] we,
                        input logic [11:0] addr, input logic [31:0] wd, input logic [3:0] exp_rdy);
        req_valid = v;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        check({nm, ".ready"}, 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
    endtask

    // Expect DEPTH cycles of zero writes on port A starting right now.
    task automatic sweep_check(input string tag);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check({tag, ".we_a"}, 32'(ram_we_a), 32'd1);
            check({tag, ".addr_a"}, 32'(ram_addr_a), 32'(k));
            check({tag, ".din_a"}, 32'(ram_din_a), 32'd0);
            check({tag, ".we_b"}, 32'(ram_we_b), 32'd0);
            check({tag, ".ready"}, 32'(req_ready), 32'd0);
            check({tag, ".init_done"}, 32'(init_done), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every presented response must match the oldest expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid[i]) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: requester %0d data %0h, none expected", i, rsp_data[i*8 +: 8]);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp", 32'({2'(i), rsp_data[i*8 +: 8]}), 32'(mon_e));
                end
            end
        end
    end

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        seed      = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        seed = 1'b0;
        @(negedge clk);
        check("rst.init_done", 32'(init_done), 32'd0);
        check("rst.ready", 32'(req_ready), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_data", rsp_data, 32'd0);
        check("rst.we_a", 32'(ram_we_a), 32'd0);
        check("rst.we_b", 32'(ram_we_b), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep_check("sweep1");

        // First RUN cycle: read a cleared word.
        step("rd5", 4'b0001, 4'b0000, pa(0, 0, 0, 5), 32'h0, 4'b0001);
        push(0, 8'h00);
        check("init_done_run", 32'(init_done), 32'd1);

        // Write then read through different requesters.
        step("wr2", 4'b0001, 4'b0001, pa(0, 0, 0, 2), 32'h0000_00A5, 4'b0001);
        push(1, 8'hA5);
        step("rd2", 4'b0010, 4'b0000, pa(0, 0, 2, 0), 32'h0, 4'b0010);

        // Move the pointer back to 0, then four-way contention on reads.
        push(3, 8'h00);
        step("ptr", 4'b1000, 4'b0000, pa(7, 0, 0, 0), 32'h0, 4'b1000);
        for (int r = 0; r < 2; r++) begin
            push(0, 8'h00); push(1, 8'h00);
            step("rr01", 4'b1111, 4'b0000, pa(3, 2, 1, 0), 32'h0, 4'b0011);
            push(2, 8'hA5); push(3, 8'h00);
            step("rr23", 4'b1111, 4'b0000, pa(3, 2, 1, 0), 32'h0, 4'b1100);
        end

        // Write on A collides with read on B: B waits one cycle.
        step("col_a", 4'b0011, 4'b0001, pa(0, 0, 4, 4), 32'h0000_0011, 4'b0001);
        push(1, 8'h11);
        step("col_a2", 4'b0010, 4'b0000, pa(0, 0, 4, 0), 32'h0, 4'b0010);

        // Two reads of the same address share the cycle.
        push(2, 8'h00); push(3, 8'h00);
        step("rdrd", 4'b1100, 4'b0000, pa(6, 6, 0, 0), 32'h0, 4'b1100);

        // Port B search wraps past unrequested indices.
        push(0, 8'hA5); push(3, 8'h11);
        step("wrapb", 4'b1001, 4'b0000, pa(4, 0, 0, 2), 32'h0, 4'b1001);

        // Write on B collides with read on A.
        push(0, 8'h00);
        step("col_b", 4'b0101, 4'b0100, pa(0, 1, 0, 1), 32'h003C_0000, 4'b0001);
        step("col_b2", 4'b0100, 4'b0100, pa(0, 1, 0, 0), 32'h003C_0000, 4'b0100);
        push(1, 8'h3C);
        step("rd1", 4'b0010, 4'b0000, pa(0, 0, 1, 0), 32'h0, 4'b0010);

        // Reset right after a read grant: the response is dropped.
        step("rd_abort", 4'b0001, 4'b0000, pa(0, 0, 0, 2), 32'h0, 4'b0001);
        rst_n     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("rst2.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst2.init_done", 32'(init_done), 32'd0);
        check("rst2.ready", 32'(req_ready), 32'd0);
        check("rst2.we_a", 32'(ram_we_a), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep_check("sweep2");

        // Previously written words are cleared again.
        push(0, 8'h00); push(1, 8'h00);
        step("post_rst", 4'b0011, 4'b0000, pa(0, 0, 4, 2), 32'h0, 4'b0011);

        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
